// File: rtl/io_arb_pkg.sv
// ----------------------------------------------------------------------------
// io_arb_pkg: shared types for the CPU/host I/O bus arbiter -- rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package io_arb_pkg;

  localparam int ACC_CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CPU_ACC   = 3'd1,
    ST_CPU_HOLD  = 3'd2,
    ST_HOST_ACC  = 3'd3,
    ST_HOST_DONE = 3'd4
  } arb_state_t;

  typedef enum logic {
    GRANT_CPU  = 1'b0,
    GRANT_HOST = 1'b1
  } grant_t;

  // On a tie the side that did not win last time gets the bus.
  function automatic grant_t rr_pick(input logic cpu_v, input logic host_req,
                                     input grant_t last_grant);
    grant_t pick;
    if (cpu_v && host_req)
      pick = (last_grant == GRANT_HOST) ? GRANT_CPU : GRANT_HOST;
    else if (host_req)
      pick = GRANT_HOST;
    else
      pick = GRANT_CPU;
    return pick;
  endfunction

endpackage

`default_nettype wire

// File: rtl/io_arb_grant.sv
// ----------------------------------------------------------------------------
// io_arb_grant: two-input round-robin picker with last-grant memory -- rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module io_arb_grant
  import io_arb_pkg::*;
(
  input  logic   CLK,
  input  logic   nRESET,
  input  logic   cpu_v,
  input  logic   host_req,
  input  logic   enable,
  output grant_t grant,
  output logic   grant_valid
);

  grant_t last_grant;

  always_comb begin
    grant       = rr_pick(cpu_v, host_req, last_grant);
    grant_valid = enable && (cpu_v || host_req);
  end

  // Resetting to HOST lets the CPU win the first tie after reset.
  always_ff @(posedge CLK) begin
    if (!nRESET)
      last_grant <= GRANT_HOST;
    else if (grant_valid)
      last_grant <= grant;
  end

endmodule

`default_nettype wire

// File: rtl/io_bus_arbiter.sv
// ----------------------------------------------------------------------------
// io_bus_arbiter: shares the I/O device bus between Z80 I/O cycles and a host
// port; host arbitration built only with IO_BUS_ARBITER_HOST_EN -- rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module io_bus_arbiter
  import io_arb_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic [15:0] A,
  input  logic [7:0]  D_cpu_out,
  output logic [7:0]  D_cpu_in,
  input  logic        nIORQ,
  input  logic        nRD,
  input  logic        nWR,
  input  logic        nM1,
  output logic        nWAIT,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [15:0] host_addr,
  input  logic [7:0]  host_wdata,
  output logic        host_ack,
  output logic [7:0]  host_rdata,
  output logic [15:0] dev_addr,
  output logic [7:0]  dev_wdata,
  input  logic [7:0]  dev_rdata,
  output logic        dev_CS,
  output logic        dev_WE,
  output logic        dev_OE
);

  localparam logic [ACC_CNT_W-1:0] LAST_CNT = ACC_CNT_W'(ACCESS_CYCLES - 1);

  arb_state_t           state;
  logic [ACC_CNT_W-1:0] cnt;
  logic                 cpu_v;
  logic                 grant_valid;

  // Interrupt acknowledge and the illegal RD+WR combination never reach the bus.
  assign cpu_v = !nIORQ && nM1 && (nRD ^ nWR);

  // CPU_HOLD is the only state in which a live CPU cycle is allowed to run on,
  // so one I/O cycle maps to exactly one device access.
  assign nWAIT = !(cpu_v && (state != ST_CPU_HOLD));

`ifdef IO_BUS_ARBITER_HOST_EN
  grant_t grant;

  io_arb_grant u_grant (
    .CLK        (CLK),
    .nRESET     (nRESET),
    .cpu_v      (cpu_v),
    .host_req   (host_req),
    .enable     (state == ST_IDLE),
    .grant      (grant),
    .grant_valid(grant_valid)
  );
`else
  logic unused_host;

  assign grant_valid = cpu_v && (state == ST_IDLE);
  assign host_ack    = 1'b0;
  assign host_rdata  = '0;
  assign unused_host = ^{host_req, host_we, host_addr, host_wdata};
`endif

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      dev_CS    <= 1'b1;
      dev_WE    <= 1'b1;
      dev_OE    <= 1'b1;
      dev_addr  <= '0;
      dev_wdata <= '0;
      D_cpu_in  <= '0;
`ifdef IO_BUS_ARBITER_HOST_EN
      host_ack   <= 1'b0;
      host_rdata <= '0;
`endif
    end else begin
`ifdef IO_BUS_ARBITER_HOST_EN
      host_ack <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          cnt <= '0;
`ifdef IO_BUS_ARBITER_HOST_EN
          if (grant_valid && (grant == GRANT_HOST)) begin
            state     <= ST_HOST_ACC;
            dev_CS    <= 1'b0;
            dev_addr  <= host_addr;
            dev_wdata <= host_wdata;
            dev_WE    <= !host_we;
            dev_OE    <= host_we;
          end else
`endif
          if (grant_valid) begin
            state     <= ST_CPU_ACC;
            dev_CS    <= 1'b0;
            dev_addr  <= A;
            dev_wdata <= D_cpu_out;
            dev_WE    <= nWR;
            dev_OE    <= nRD;
          end
        end

        // An early nIORQ release still completes the access; HOLD then exits at once.
        ST_CPU_ACC: begin
          cnt <= cnt + ACC_CNT_W'(1);
          if (cnt == LAST_CNT) begin
            if (!dev_OE)
              D_cpu_in <= dev_rdata;
            dev_CS <= 1'b1;
            dev_WE <= 1'b1;
            dev_OE <= 1'b1;
            state  <= ST_CPU_HOLD;
          end
        end

        ST_CPU_HOLD: begin
          if (nIORQ)
            state <= ST_IDLE;
        end

`ifdef IO_BUS_ARBITER_HOST_EN
        ST_HOST_ACC: begin
          cnt <= cnt + ACC_CNT_W'(1);
          if (cnt == LAST_CNT) begin
            if (!dev_OE)
              host_rdata <= dev_rdata;
            dev_CS   <= 1'b1;
            dev_WE   <= 1'b1;
            dev_OE   <= 1'b1;
            host_ack <= 1'b1;
            state    <= ST_HOST_DONE;
          end
        end

        ST_HOST_DONE: begin
          state <= ST_IDLE;
        end
`endif

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
